// File: rtl/univ_reg_if.sv
// Control/data bundle for univ_reg: the master drives mode, data and serial input,
// and the slave (the register) returns its contents and status flags.
interface univ_reg_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             carry;
   logic             zero;

   modport master (
      output en, mode, d, sin,
      input  q, sout, carry, zero
   );

   modport slave (
      input  en, mode, d, sin,
      output q, sout, carry, zero
   );
endinterface

// File: rtl/univ_reg.sv
// WIDTH-bit universal register: hold, load, logical shift, rotate, increment and
// decrement, with a registered serial-out and wrap/borrow flag and a live zero flag.
module univ_reg #(
   parameter int unsigned          WIDTH     = 8,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic          clk,
   input  logic          reset,
   univ_reg_if.slave     bus
);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_INC  = 3'b110,
      MODE_DEC  = 3'b111
   } mode_e;

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("univ_reg: WIDTH must be >= 2");
      end
   endgenerate

   mode_e            op;
   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
   logic             carry_q, carry_d;

   assign op = mode_e'(bus.mode);

   always_comb begin
      q_d     = q_q;
      sout_d  = sout_q;
      carry_d = carry_q;
      if (bus.en) begin
         unique case (op)
            MODE_HOLD: begin
            end
            MODE_LOAD: begin
               q_d     = bus.d;
               carry_d = 1'b0;
            end
            MODE_SHL: begin
               q_d     = {q_q[WIDTH-2:0], bus.sin};
               sout_d  = q_q[WIDTH-1];
               carry_d = 1'b0;
            end
            MODE_SHR: begin
               q_d     = {bus.sin, q_q[WIDTH-1:1]};
               sout_d  = q_q[0];
               carry_d = 1'b0;
            end
            MODE_ROL: begin
               q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               sout_d  = q_q[WIDTH-1];
               carry_d = 1'b0;
            end
            MODE_ROR: begin
               q_d     = {q_q[0], q_q[WIDTH-1:1]};
               sout_d  = q_q[0];
               carry_d = 1'b0;
            end
            MODE_INC: begin
               q_d     = q_q + WIDTH'(1);
               carry_d = &q_q;
            end
            MODE_DEC: begin
               q_d     = q_q - WIDTH'(1);
               carry_d = ~|q_q;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q     <= RESET_VAL;
         sout_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         sout_q  <= sout_d;
         carry_q <= carry_d;
      end
   end

   assign bus.q     = q_q;
   assign bus.sout  = sout_q;
   assign bus.carry = carry_q;
   assign bus.zero  = (q_q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// Directed bench for univ_reg: two instances (RESET_VAL=A5 and 0) share stimulus.
module tb_univ_reg;

   localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                          ROL  = 3'b100, ROR  = 3'b101, INC = 3'b110, DEC = 3'b111;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   univ_reg_if #(.WIDTH(8)) if_a ();
   univ_reg_if #(.WIDTH(8)) if_b ();

   univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a)
   );

   univ_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic e, input logic [2:0] m,
                       input logic [7:0] dv, input logic s);
      reset     = rst;
      if_a.en   = e;  if_b.en   = e;
      if_a.mode = m;  if_b.mode = m;
      if_a.d    = dv; if_b.d    = dv;
      if_a.sin  = s;  if_b.sin  = s;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [7:0] q, input logic so,
                        input logic c, input logic z);
      check({tag, ".q"},     32'(if_a.q),     32'(q));
      check({tag, ".sout"},  32'(if_a.sout),  32'(so));
      check({tag, ".carry"}, 32'(if_a.carry), 32'(c));
      check({tag, ".zero"},  32'(if_a.zero),  32'(z));
   endtask

   task automatic chk_b(input string tag, input logic [7:0] q, input logic so,
                        input logic c, input logic z);
      check({tag, ".bq"},     32'(if_b.q),     32'(q));
      check({tag, ".bsout"},  32'(if_b.sout),  32'(so));
      check({tag, ".bcarry"}, 32'(if_b.carry), 32'(c));
      check({tag, ".bzero"},  32'(if_b.zero),  32'(z));
   endtask

   initial begin
      reset = 1'b0;
      if_a.en = 1'b0; if_a.mode = HOLD; if_a.d = '0; if_a.sin = 1'b0;
      if_b.en = 1'b0; if_b.mode = HOLD; if_b.d = '0; if_b.sin = 1'b0;
      @(negedge clk);

      // reset beats LOAD
      step(1, 1, LOAD, 8'hFF, 0);  chk_a("rst", 8'hA5, 0, 0, 0);  chk_b("rst", 8'h00, 0, 0, 1);

      // load / shift
      step(0, 1, LOAD, 8'h81, 0);  chk_a("ld81", 8'h81, 0, 0, 0);
      step(0, 1, SHL,  8'hFF, 0);  chk_a("shl",  8'h02, 1, 0, 0);
      step(0, 1, SHR,  8'hFF, 1);  chk_a("shr",  8'h81, 0, 0, 0);

      // rotate; sin must be ignored
      step(0, 1, ROL,  8'h00, 0);  chk_a("rol",  8'h03, 1, 0, 0);
      step(0, 1, ROR,  8'h00, 0);  chk_a("ror1", 8'h81, 1, 0, 0);
      step(0, 1, ROR,  8'h00, 0);  chk_a("ror2", 8'hC0, 1, 0, 0);

      // increment / decrement wrap
      step(0, 1, LOAD, 8'hFF, 0);  chk_a("ldff", 8'hFF, 1, 0, 0);
      step(0, 1, INC,  8'h00, 0);  chk_a("inc1", 8'h00, 1, 1, 1);
      step(0, 1, INC,  8'h00, 0);  chk_a("inc2", 8'h01, 1, 0, 0);
      step(0, 1, DEC,  8'h00, 0);  chk_a("dec1", 8'h00, 1, 0, 1);
      step(0, 1, LOAD, 8'h00, 0);  chk_a("ld00", 8'h00, 1, 0, 1);
      step(0, 1, DEC,  8'h00, 0);  chk_a("dec0", 8'hFF, 1, 1, 0);

      // en=0 and HOLD preserve everything, including carry
      step(0, 0, INC,  8'h12, 1);  chk_a("dis_inc",  8'hFF, 1, 1, 0);
      step(0, 0, SHL,  8'h12, 0);  chk_a("dis_shl",  8'hFF, 1, 1, 0);
      step(0, 0, LOAD, 8'h12, 0);  chk_a("dis_ld",   8'hFF, 1, 1, 0);
      step(0, 1, HOLD, 8'h12, 1);  chk_a("hold",     8'hFF, 1, 1, 0);
      chk_b("dis", 8'hFF, 1, 1, 0);

      // reset aborts a shift sequence, shifting resumes from the reset value
      step(0, 1, LOAD, 8'h81, 0);  chk_a("ld81b", 8'h81, 1, 0, 0);
      step(0, 1, SHL,  8'h00, 1);  chk_a("seq1",  8'h03, 1, 0, 0);
      step(1, 1, SHL,  8'h00, 1);  chk_a("seqrst", 8'hA5, 0, 0, 0);
      chk_b("seqrst", 8'h00, 0, 0, 1);
      step(0, 1, SHL,  8'h00, 0);  chk_a("seq2",  8'h4A, 1, 0, 0);
      chk_b("seq2", 8'h00, 0, 0, 1);
      step(0, 1, SHL,  8'h00, 1);  chk_a("seq3",  8'h95, 0, 0, 0);
      chk_b("seq3", 8'h01, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
